bsmm_operand_loader: RTL and testbench
======================================

# bsmm_operand_loader

Upstream feeder for `BitSerialMatrixMultiply`. Accepts a stream of 32-bit operand words over a valid/ready handshake and assembles them into the 10-word `values` vector. Launches the multiplier with a one-cycle `start` pulse and holds `values` stable for the whole compute window. A fill buffer lets the next vector load while the current one computes.

## Interface
Parameters:
- `N_VALUES`, 10, words per operand vector; matches multiplier `values` depth.
- `WIDTH`, 32, bits per word.
- `COMPUTE_CYCLES`, 40, cycles `values` stays frozen after `start`; ≥1.

Ports:
- `clk`  in  1  single clock, all state on rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  `in_data` valid.
- `in_ready`  out  1  loader can accept a word.
- `in_data`  in  WIDTH  operand word; opaque bits, sign irrelevant.
- `in_last`  in  1  final word of a short vector; rest is zero-filled.
- `values`  out  N_VALUES×WIDTH  packed `[N_VALUES-1:0][WIDTH-1:0]`, to multiplier.
- `start`  out  1  one-cycle launch pulse, to multiplier.
- `busy`  out  1  compute window active.
- `done`  out  1  one-cycle pulse when compute window ends.

## Operation
- Word accepted on `in_valid && in_ready` at a rising edge. The k-th accepted word since the last launch goes to `buf[k]`; `wr_idx` increments.
- `buf_full` sets when either:
  - the word at index N_VALUES-1 is accepted, or
  - any word is accepted with `in_last=1`.
- `in_ready = !buf_full` (combinational from register).
- `in_last` on index N_VALUES-1 behaves the same as without it.
- Remaining `buf` entries are zero; `buf` is cleared at every launch and at reset.
- Compute counter `cnt`: `busy = (cnt != 0)`.
- Launch edge: `buf_full && cnt==0`. At that edge:
  - `values <= buf`, `start <= 1`, `cnt <= COMPUTE_CYCLES`
  - `buf <= 0`, `buf_full <= 0`, `wr_idx <= 0`
- `start` clears on the next edge.
- While `cnt != 0`: decrement each cycle. On the 1→0 edge, `done <= 1` for one cycle.
- A launch may occur on the same edge that `done` is asserted. The next `start` follows back-to-back.
- `values` changes only on launch edges.
- Reset (async, mid-operation included): every output and register returns to its reset value immediately, any in-flight word and vector are discarded, and no `done` is issued for an aborted compute.

## Timing
- Reset values: `values=0`, `start=0`, `busy=0`, `done=0`, `in_ready=1`, `cnt=0`, `wr_idx=0`.
- Last word accepted at edge E with multiplier idle:
  - `buf_full=1`, `in_ready=0` in cycle E..E+1.
  - Launch at E+1: `start=1`, `values` valid, `busy=1` during cycle E+1..E+2.
- `busy` high for exactly COMPUTE_CYCLES cycles, starting with the `start` cycle.
- `done` is high in the first cycle with `busy=0`.
- Buffer full while busy: `in_ready` stays 0 until the launch edge, then 1 in the following cycle.
- `in_valid` with `in_ready=0`: ignored. The source must hold `in_data`/`in_last`.
- Throughput: one word/cycle during fill. Minimum spacing between launches is `max(COMPUTE_CYCLES, N_VALUES+1)` cycles.

## Structure
- Shared package `bsmm_pkg`:
  - `BSMM_N_VALUES=10`, `BSMM_WIDTH=32`
  - `typedef logic [BSMM_N_VALUES-1:0][BSMM_WIDTH-1:0] bsmm_vec_t`
  - `BSMM_COMPUTE_CYCLES` (shared with the multiplier so the window matches its latency).
- One sub-module `bsmm_busy_timer`: load/countdown counter with `busy` and `done` outputs.
- Fill buffer, index counter and launch logic stay in the top.

## Test plan
- Stream 1,3,5,19,24,12,23,135,0xFFFFFFE9,20 on consecutive cycles after reset. Check:
  - `start` is a single pulse one edge after the 10th accept.
  - `values[0]=1`, …, `values[8]=0xFFFFFFE9`, `values[9]=20`.
  - `busy` lasts 40 cycles; `done` is one pulse.
- Send 7,8,9 with `in_last` on 9. Check `values[0..2]=7,8,9`, `values[3..9]=0`, and a single `start`.
- Send a second full vector 100..109 during busy. Check:
  - `in_ready` drops after the 10th word.
  - The second `start` coincides with the first `done`.
  - `values` holds vector 1 until that edge.
- Drive random `in_valid` gaps and hold words while `in_ready=0`. Check no duplicated or lost words, and word order matches `values` index.
- Assert reset mid-fill (after 4 words), then mid-compute (cycle 20). Check:
  - All outputs are immediately at reset values.
  - No `done` is issued.
  - The next full vector loads from index 0.
- With `COMPUTE_CYCLES=1`, send back-to-back vectors. Check launches are spaced by exactly N_VALUES+1 cycles and `busy` is a single cycle.

Source files
------------

// File: rtl/bsmm_pkg.sv
// rtl/bsmm_pkg.sv - shared constants and vector type for the bit-serial multiplier path
package bsmm_pkg;

   localparam int BSMM_N_VALUES       = 10;
   localparam int BSMM_WIDTH          = 32;
   // Matches the multiplier latency so the frozen window covers the whole computation
   localparam int BSMM_COMPUTE_CYCLES = 40;

   typedef logic [BSMM_N_VALUES-1:0][BSMM_WIDTH-1:0] bsmm_vec_t;

endpackage

// File: rtl/bsmm_operand_loader_if.sv
// rtl/bsmm_operand_loader_if.sv - operand word stream with valid/ready handshake
interface bsmm_operand_loader_if
   import bsmm_pkg::*;
#(
   parameter int WIDTH = BSMM_WIDTH
);

   logic             valid;
   logic             ready;
   logic [WIDTH-1:0] data;
   logic             last;

   modport master (output valid, output data, output last, input ready);
   modport slave  (input valid, input data, input last, output ready);

endinterface

// File: rtl/bsmm_busy_timer.sv
// rtl/bsmm_busy_timer.sv - compute window counter producing busy, done and a free flag
module bsmm_busy_timer
   import bsmm_pkg::*;
#(
   parameter int COMPUTE_CYCLES = BSMM_COMPUTE_CYCLES
)(
   input  logic clk,
   input  logic rst,
   input  logic load,
   output logic busy,
   output logic done,
   output logic free
);

   localparam int CNT_W = $clog2(COMPUTE_CYCLES + 1);

   logic [CNT_W-1:0] cnt;

   assign busy = (cnt != '0);
   // The window ending on this edge counts as free so a waiting vector launches without a bubble
   assign free = (cnt <= CNT_W'(1));

   // Load on launch, otherwise count down; done marks every window that runs to its last cycle
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt  <= '0;
         done <= 1'b0;
      end else begin
         done <= (cnt == CNT_W'(1));
         if (load) begin
            cnt <= CNT_W'(COMPUTE_CYCLES);
         end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
         end
      end
   end

endmodule

// File: rtl/bsmm_operand_loader.sv
// rtl/bsmm_operand_loader.sv - assembles operand words into a vector and launches the multiplier
module bsmm_operand_loader
   import bsmm_pkg::*;
#(
   parameter int N_VALUES       = BSMM_N_VALUES,
   parameter int WIDTH          = BSMM_WIDTH,
   parameter int COMPUTE_CYCLES = BSMM_COMPUTE_CYCLES
)(
   input  logic                              clk,
   input  logic                              rst,
   bsmm_operand_loader_if.slave              operand,
   output logic [N_VALUES-1:0][WIDTH-1:0]    values,
   output logic                              start,
   output logic                              busy,
   output logic                              done
);

   localparam int IDX_W = $clog2(N_VALUES);

   logic [N_VALUES-1:0][WIDTH-1:0] fill_buf;
   logic [IDX_W-1:0]               wr_idx;
   logic                           buf_full;
   logic                           accept;
   logic                           launch;
   logic                           window_free;

   assign operand.ready = !buf_full;
   assign accept        = operand.valid && !buf_full;
   assign launch        = buf_full && window_free;

   bsmm_busy_timer #(
      .COMPUTE_CYCLES (COMPUTE_CYCLES)
   ) u_timer (
      .clk  (clk),
      .rst  (rst),
      .load (launch),
      .busy (busy),
      .done (done),
      .free (window_free)
   );

   // Fill the buffer word by word; on launch hand it to values and start an empty fill
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fill_buf <= '0;
         wr_idx   <= '0;
         buf_full <= 1'b0;
         values   <= '0;
         start    <= 1'b0;
      end else begin
         start <= 1'b0;
         if (launch) begin
            values   <= fill_buf;
            start    <= 1'b1;
            fill_buf <= '0;
            buf_full <= 1'b0;
            wr_idx   <= '0;
         end else if (accept) begin
            fill_buf[wr_idx] <= operand.data;
            wr_idx           <= wr_idx + 1'b1;
            if (operand.last || (wr_idx == IDX_W'(N_VALUES - 1))) begin
               buf_full <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_bsmm_operand_loader.sv
// tb/tb_bsmm_operand_loader.sv - scoreboard bench for bsmm_operand_loader
module tb_bsmm_operand_loader;
   import bsmm_pkg::*;

   logic      clk;
   logic      rst;
   bsmm_vec_t values, values1;
   logic      start, busy, done;
   logic      start1, busy1, done1;

   bsmm_operand_loader_if src ();
   bsmm_operand_loader_if src1 ();

   bsmm_operand_loader dut (
      .clk(clk), .rst(rst), .operand(src.slave),
      .values(values), .start(start), .busy(busy), .done(done)
   );

   bsmm_operand_loader #(.COMPUTE_CYCLES(1)) dut1 (
      .clk(clk), .rst(rst), .operand(src1.slave),
      .values(values1), .start(start1), .busy(busy1), .done(done1)
   );

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int acc_cyc = 0;
   int start_count = 0;
   int done_count = 0;
   int n_start1 = 0;
   int last1 = 0;
   logic prev_start1 = 1'b0;
   bsmm_vec_t sb[$];
   bsmm_vec_t sb1[$];

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Scoreboard for the main DUT: every launch must present the oldest queued vector
   always @(negedge clk) begin
      if (rst) begin
         if (start) begin
            if (sb.size() == 0) begin
               check_eq("unexpected_start", 64'd1, 64'd0);
            end else begin
               bsmm_vec_t e;
               e = sb.pop_front();
               for (int i = 0; i < BSMM_N_VALUES; i++)
                  check_eq($sformatf("values[%0d]", i), 64'(values[i]), 64'(e[i]));
            end
            start_count++;
         end
         if (done) done_count++;
      end
   end

   // Monitor for the single-cycle-window DUT: spacing, busy width, values
   always @(negedge clk) begin
      if (!rst) begin
         prev_start1 = 1'b0;
      end else begin
         if (prev_start1) begin
            check_eq("c1_busy_single", 64'(busy1), 64'd0);
            check_eq("c1_done", 64'(done1), 64'd1);
         end
         if (start1) begin
            if (sb1.size() == 0) begin
               check_eq("c1_unexpected_start", 64'd1, 64'd0);
            end else begin
               bsmm_vec_t e;
               e = sb1.pop_front();
               for (int i = 0; i < BSMM_N_VALUES; i++)
                  check_eq($sformatf("c1_values[%0d]", i), 64'(values1[i]), 64'(e[i]));
            end
            if (n_start1 > 0) check_eq("c1_spacing", 64'(cyc - last1), 64'(BSMM_N_VALUES + 1));
            last1 = cyc;
            n_start1++;
         end
         prev_start1 = start1;
      end
   end

   task automatic push_word(input logic [31:0] d, input logic l, input int gap);
      int g;
      src.valid = 1'b0;
      repeat (gap) begin
         @(posedge clk);
         #1;
      end
      src.valid = 1'b1;
      src.data  = d;
      src.last  = l;
      g = 0;
      forever begin
         @(negedge clk);
         if (src.ready) break;
         g++;
         if (g > 500) begin
            check_eq("ready_timeout", 64'd0, 64'd1);
            break;
         end
      end
      @(posedge clk);
      #1;
      src.valid = 1'b0;
      src.last  = 1'b0;
      acc_cyc   = cyc;
   endtask

   task automatic send_vec(input bsmm_vec_t v, input int n, input logic use_last, input int maxgap);
      bsmm_vec_t e;
      e = '0;
      for (int i = 0; i < n; i++) e[i] = v[i];
      sb.push_back(e);
      for (int i = 0; i < n; i++)
         push_word(v[i], use_last && (i == n - 1), (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0);
   endtask

   task automatic wait_start(output int c);
      int g;
      g = 0;
      do begin
         @(negedge clk);
         g++;
      end while (!start && g < 500);
      if (!start) check_eq("start_timeout", 64'd0, 64'd1);
      c = cyc;
   endtask

   task automatic wait_idle();
      int g;
      g = 0;
      while ((busy || sb.size() != 0) && g < 1000) begin
         @(negedge clk);
         g++;
      end
      check_eq("idle_reached", 64'(busy), 64'd0);
      @(negedge clk);
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_values"}, 64'(values), 64'd0);
      check_eq({tag, "_start"}, 64'(start), 64'd0);
      check_eq({tag, "_busy"}, 64'(busy), 64'd0);
      check_eq({tag, "_done"}, 64'(done), 64'd0);
      check_eq({tag, "_ready"}, 64'(src.ready), 64'd1);
   endtask

   initial begin
      bsmm_vec_t v, va, vb;
      int s1, s2, n, starts_in, hold_bad, d0;

      src.valid = 1'b0; src.data = '0; src.last = 1'b0;
      src1.valid = 1'b0; src1.data = '0; src1.last = 1'b0;
      rst = 1'b0;
      #2;
      check_reset_outputs("reset");
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;

      // Full vector, consecutive words
      v = '0;
      v[0] = 32'd1; v[1] = 32'd3; v[2] = 32'd5; v[3] = 32'd19; v[4] = 32'd24;
      v[5] = 32'd12; v[6] = 32'd23; v[7] = 32'd135; v[8] = 32'hFFFFFFE9; v[9] = 32'd20;
      send_vec(v, 10, 1'b0, 0);
      wait_start(s1);
      check_eq("start_latency", 64'(s1 - acc_cyc), 64'd1);
      n = 0; starts_in = 0;
      while (busy && n < 500) begin
         n++;
         if (start) starts_in++;
         @(negedge clk);
      end
      check_eq("busy_len", 64'(n), 64'd40);
      check_eq("start_single", 64'(starts_in), 64'd1);
      check_eq("done_pulse", 64'(done), 64'd1);
      @(negedge clk);
      check_eq("done_clear", 64'(done), 64'd0);

      // Short vector ended by in_last
      @(posedge clk); #1;
      v = '0; v[0] = 32'd7; v[1] = 32'd8; v[2] = 32'd9;
      send_vec(v, 3, 1'b1, 0);
      wait_start(s1);
      check_eq("short_latency", 64'(s1 - acc_cyc), 64'd1);
      wait_idle();

      // Second vector loaded during compute, back-to-back launch
      @(posedge clk); #1;
      for (int i = 0; i < 10; i++) begin
         va[i] = 32'(200 + i);
         vb[i] = 32'(100 + i);
      end
      send_vec(va, 10, 1'b0, 0);
      wait_start(s1);
      @(posedge clk); #1;
      send_vec(vb, 10, 1'b0, 0);
      @(negedge clk);
      check_eq("ready_drop", 64'(src.ready), 64'd0);
      hold_bad = 0; n = 0;
      while (!start && n < 500) begin
         if (values !== va) hold_bad++;
         n++;
         @(negedge clk);
      end
      check_eq("hold_v1", 64'(hold_bad), 64'd0);
      check_eq("start_with_done", 64'(done), 64'd1);
      check_eq("launch_spacing", 64'(cyc - s1), 64'd40);
      check_eq("ready_after_launch", 64'(src.ready), 64'd1);
      check_eq("busy_continuous", 64'(busy), 64'd1);
      wait_idle();

      // Random gaps, stalls while full, in_last on the final index
      @(posedge clk); #1;
      for (int k = 0; k < 3; k++) begin
         for (int i = 0; i < 10; i++) v[i] = $urandom;
         send_vec(v, 10, (k == 2), 3);
      end
      wait_idle();

      // Reset mid-fill
      @(posedge clk); #1;
      for (int i = 0; i < 10; i++) v[i] = 32'(300 + i);
      send_vec(v, 4, 1'b0, 0);
      #2 rst = 1'b0;
      #1 check_reset_outputs("rst_fill");
      sb.delete();
      #2 rst = 1'b1;
      @(posedge clk); #1;

      // Reset mid-compute
      send_vec(v, 10, 1'b0, 0);
      wait_start(s1);
      repeat (19) @(negedge clk);
      #2 rst = 1'b0;
      #1 check_reset_outputs("rst_compute");
      d0 = done_count;
      #2 rst = 1'b1;
      repeat (60) @(negedge clk);
      check_eq("no_done_abort", 64'(done_count), 64'(d0));

      // Vector after reset loads from index 0
      @(posedge clk); #1;
      for (int i = 0; i < 10; i++) v[i] = 32'(400 + i);
      send_vec(v, 10, 1'b0, 0);
      wait_idle();

      // Single-cycle window: back-to-back vectors on the second instance
      @(posedge clk); #1;
      for (int k = 0; k < 3; k++) begin
         v = '0;
         for (int i = 0; i < 10; i++) v[i] = 32'(k * 16 + i + 1);
         sb1.push_back(v);
      end
      src1.valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         for (int i = 0; i < 10; i++) begin
            int g;
            src1.data = 32'(k * 16 + i + 1);
            g = 0;
            do begin
               @(negedge clk);
               g++;
            end while (!src1.ready && g < 100);
            if (!src1.ready) check_eq("c1_ready_timeout", 64'd0, 64'd1);
            @(posedge clk); #1;
         end
      end
      src1.valid = 1'b0;
      repeat (6) @(negedge clk);

      check_eq("start_total", 64'(start_count), 64'd9);
      check_eq("done_total", 64'(done_count), 64'd8);
      check_eq("sb_empty", 64'(sb.size()), 64'd0);
      check_eq("c1_start_total", 64'(n_start1), 64'd3);
      check_eq("c1_sb_empty", 64'(sb1.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
